// File: rtl/multi_cycle_timer.sv
// multi_cycle_timer
//   Multi-channel countdown timer for cycle-budget and watchdog measurement.
//   Each channel loads a count, decrements it on every tick while running and
//   flags expiry with a one-cycle done pulse plus a sticky interrupt bit.
//   Channels are one-shot (return to IDLE on expiry) or periodic (auto-reload).
//
//   Optional feature macro: MULTI_CYCLE_TIMER_PRESCALE_EN
//     defined   : adds prescale_i; tick = enable_i on every (prescale_i+1)-th
//                 enabled cycle, using one prescale counter shared by all channels.
//     undefined : tick = enable_i.
//
// Ports
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   ch_sel_i      channel addressed by start/stop/readout (>= NUM_CH: none)
//   start_i       load cycles_i/mode_i into the selected channel and run
//   stop_i        abort the selected channel (wins over start_i)
//   cycles_i      load/reload value (0 means the start is ignored)
//   mode_i        0 = one-shot, 1 = periodic
//   enable_i      global count enable
//   prescale_i    tick divider, only with MULTI_CYCLE_TIMER_PRESCALE_EN
//   irq_clr_i     write-1-to-clear mask for irq_status_o
//   readout_o     registered post-edge count of the selected channel
//   busy_o        per-channel RUN state (this vector is the FSM state)
//   done_o        one-cycle pulse per channel on expiry
//   irq_status_o  sticky per-channel expiry flags
//   irq_o         OR of irq_status_o
//
// Handshake: start_i/stop_i are single-cycle commands sampled on every rising
// edge; there is no ready, a command is acted on in the cycle it is presented.

`ifndef kCYCLE_COUNTER_WIDTH
`define kCYCLE_COUNTER_WIDTH 16
`endif

module multi_cycle_timer #(
   parameter int CNT_WIDTH = `kCYCLE_COUNTER_WIDTH,
   parameter int NUM_CH    = 4,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int PRE_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [CH_W-1:0]      ch_sel_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [CNT_WIDTH-1:0] cycles_i,
   input  logic                 mode_i,
   input  logic                 enable_i,
`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
   input  logic [PRE_WIDTH-1:0] prescale_i,
`endif
   input  logic [NUM_CH-1:0]    irq_clr_i,
   output logic [CNT_WIDTH-1:0] readout_o,
   output logic [NUM_CH-1:0]    busy_o,
   output logic [NUM_CH-1:0]    done_o,
   output logic [NUM_CH-1:0]    irq_status_o,
   output logic                 irq_o
);

   if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("multi_cycle_timer: NUM_CH must be 1..16");
   end
   if (PRE_WIDTH < 1) begin : g_bad_pre_width
      $error("multi_cycle_timer: PRE_WIDTH must be >= 1");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               state_q  [NUM_CH];
   state_t               state_d  [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_q    [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_d    [NUM_CH];
   logic [CNT_WIDTH-1:0] reload_q [NUM_CH];
   logic [CNT_WIDTH-1:0] reload_d [NUM_CH];
   logic [NUM_CH-1:0]    mode_q;
   logic [NUM_CH-1:0]    mode_d;
   logic [NUM_CH-1:0]    sel_hit;
   logic [NUM_CH-1:0]    expire;
   logic [NUM_CH-1:0]    busy_d;
   logic [NUM_CH-1:0]    irq_d;
   logic [CNT_WIDTH-1:0] readout_d;
   logic                 tick;

`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
   // Shared divider; it is held at 0 while every channel is idle so the first
   // tick after a start from all-idle always comes prescale_i+1 cycles later.
   logic [PRE_WIDTH-1:0] pre_q;
   logic                 pre_wrap;

   assign pre_wrap = (pre_q == prescale_i);
   assign tick     = enable_i && pre_wrap;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pre_q <= '0;
      end else if (busy_o == '0) begin
         pre_q <= '0;
      end else if (enable_i) begin
         pre_q <= pre_wrap ? '0 : pre_q + PRE_WIDTH'(1);
      end
   end
`else
   assign tick = enable_i;
`endif

   // Next-state logic. Priority per channel: stop, accepted start, countdown.
   // A restart therefore pre-empts an expiry in the same cycle.
   always_comb begin
      readout_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]  = state_q[i];
         cnt_d[i]    = cnt_q[i];
         reload_d[i] = reload_q[i];
         mode_d[i]   = mode_q[i];
         expire[i]   = 1'b0;
         // Selects >= NUM_CH match no channel, so they are naturally ignored.
         sel_hit[i]  = (ch_sel_i == CH_W'(i));

         if (sel_hit[i] && stop_i) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
         end else if (sel_hit[i] && start_i && (cycles_i != '0)) begin
            state_d[i]  = ST_RUN;
            cnt_d[i]    = cycles_i;
            reload_d[i] = cycles_i;
            mode_d[i]   = mode_i;
         end else if ((state_q[i] == ST_RUN) && tick) begin
            if (cnt_q[i] == CNT_WIDTH'(1)) begin
               expire[i] = 1'b1;
               if (mode_q[i]) begin
                  cnt_d[i] = reload_q[i];
               end else begin
                  cnt_d[i]   = '0;
                  state_d[i] = ST_IDLE;
               end
            end else if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
            end
         end

         busy_d[i] = (state_d[i] == ST_RUN);
         if (sel_hit[i]) begin
            readout_d = cnt_d[i];
         end
      end
      // Set beats clear when both land in the same cycle.
      irq_d = (irq_status_o & ~irq_clr_i) | expire;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= ST_IDLE;
            cnt_q[i]    <= '0;
            reload_q[i] <= '0;
         end
         mode_q       <= '0;
         readout_o    <= '0;
         busy_o       <= '0;
         done_o       <= '0;
         irq_status_o <= '0;
         irq_o        <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= state_d[i];
            cnt_q[i]    <= cnt_d[i];
            reload_q[i] <= reload_d[i];
         end
         mode_q       <= mode_d;
         readout_o    <= readout_d;
         busy_o       <= busy_d;
         done_o       <= expire;
         irq_status_o <= irq_d;
         irq_o        <= |irq_d;
      end
   end

endmodule

// File: tb/tb_multi_cycle_timer.sv
// tb_multi_cycle_timer
//   Directed self-checking bench for multi_cycle_timer. A 4-channel instance
//   carries most scenarios; a 3-channel instance exists so that a select value
//   equal to NUM_CH is representable on the 2-bit select port.

module tb_multi_cycle_timer;

   localparam int CW = 16;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rstn_i;
   always #5 clk_i = ~clk_i;

   // ---------------- 4-channel DUT ----------------
   logic [1:0]    ch_sel;
   logic          start;
   logic          stop;
   logic [CW-1:0] cycles;
   logic          mode;
   logic          enable;
   logic [3:0]    irq_clr;
   logic [CW-1:0] readout;
   logic [3:0]    busy;
   logic [3:0]    done;
   logic [3:0]    irq_status;
   logic          irq;
`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
   logic [7:0]    prescale;
`endif

   multi_cycle_timer #(.CNT_WIDTH(CW), .NUM_CH(4), .PRE_WIDTH(8)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .ch_sel_i(ch_sel), .start_i(start),
      .stop_i(stop), .cycles_i(cycles), .mode_i(mode), .enable_i(enable),
`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
      .prescale_i(prescale),
`endif
      .irq_clr_i(irq_clr), .readout_o(readout), .busy_o(busy), .done_o(done),
      .irq_status_o(irq_status), .irq_o(irq)
   );

   // ---------------- 3-channel DUT ----------------
   logic [1:0]    sel3;
   logic          start3;
   logic          stop3;
   logic [2:0]    irq_clr3;
   logic [CW-1:0] readout3;
   logic [2:0]    busy3;
   logic [2:0]    done3;
   logic [2:0]    irq_status3;
   logic          irq3;

   multi_cycle_timer #(.CNT_WIDTH(CW), .NUM_CH(3), .PRE_WIDTH(8)) dut3 (
      .clk_i(clk_i), .rstn_i(rstn_i), .ch_sel_i(sel3), .start_i(start3),
      .stop_i(stop3), .cycles_i(cycles), .mode_i(mode), .enable_i(enable),
`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
      .prescale_i(prescale),
`endif
      .irq_clr_i(irq_clr3), .readout_o(readout3), .busy_o(busy3), .done_o(done3),
      .irq_status_o(irq_status3), .irq_o(irq3)
   );

   int n_vec = 0;
   int n_err = 0;

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue_start(input logic [1:0] ch, input int n, input logic m);
      ch_sel = ch; cycles = CW'(n); mode = m; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn_i = 1'b0; ch_sel = '0; start = 1'b0; stop = 1'b0; cycles = '0;
      mode = 1'b0; enable = 1'b1; irq_clr = '0;
      sel3 = '0; start3 = 1'b0; stop3 = 1'b0; irq_clr3 = '0;
`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
      prescale = '0;
`endif
      #2;
      n_vec++;
      if ({readout, busy, done, irq_status, irq} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got ro=%0d busy=%b done=%b irqs=%b irq=%b, want all 0",
                  readout, busy, done, irq_status, irq);
      end
      step(); step();
      rstn_i = 1'b1;
      step();
      n_vec++;
      if ({busy, done, irq_status, irq, busy3, done3} !== '0) begin
         n_err++;
         $display("FAIL reset_release: got busy=%b done=%b irqs=%b irq=%b, want all 0",
                  busy, done, irq_status, irq);
      end
   endtask

   task automatic test_one_shot();
      logic [CW-1:0] exp_ro;
      issue_start(2'd0, 5, 1'b0);
      n_vec++;
      if (busy !== 4'b0001 || readout !== CW'(5)) begin
         n_err++;
         $display("FAIL one_shot_load: got busy=%b ro=%0d, want busy=0001 ro=5", busy, readout);
      end
      for (int c = 1; c <= 6; c++) begin
         step();
         exp_ro = (c >= 5) ? '0 : CW'(5 - c);
         n_vec++;
         if (done !== ((c == 5) ? 4'b0001 : 4'b0000) || busy[0] !== (c < 5) ||
             readout !== exp_ro || irq !== (c >= 5)) begin
            n_err++;
            $display("FAIL one_shot_c%0d: got done=%b busy=%b ro=%0d irq=%b, want done0=%0d busy0=%0d ro=%0d irq=%0d",
                     c, done, busy, readout, irq, c == 5, c < 5, exp_ro, c >= 5);
         end
      end
      n_vec++;
      if (irq_status !== 4'b0001) begin
         n_err++;
         $display("FAIL one_shot_irqs: got %b want 0001", irq_status);
      end
      irq_clr = 4'b0001;
      step();
      irq_clr = 4'b0000;
      n_vec++;
      if (irq_status !== 4'b0000 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL one_shot_irq_clear: got irqs=%b irq=%b want 0000/0", irq_status, irq);
      end
   endtask

   task automatic test_periodic();
      logic [CW-1:0] exp_ro;
      logic          exp_done;
      issue_start(2'd2, 3, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         if (c == 7) stop = 1'b1;
         step();
         stop = 1'b0;
         exp_done = (c == 3) || (c == 6);
         if (c >= 7)          exp_ro = '0;
         else if (c % 3 == 0) exp_ro = CW'(3);
         else                 exp_ro = CW'(3 - (c % 3));
         n_vec++;
         if (done[2] !== exp_done || busy[2] !== (c < 7) || readout !== exp_ro) begin
            n_err++;
            $display("FAIL periodic_c%0d: got done=%b busy=%b ro=%0d, want done2=%0d busy2=%0d ro=%0d",
                     c, done, busy, readout, exp_done, c < 7, exp_ro);
         end
      end
      n_vec++;
      if (irq_status !== 4'b0100) begin
         n_err++;
         $display("FAIL periodic_irqs_after_stop: got %b want 0100", irq_status);
      end
      irq_clr = 4'b0100;
      step();
      irq_clr = 4'b0000;
   endtask

   task automatic test_pause();
      logic [CW-1:0] exp_ro_tbl [6];
      exp_ro_tbl = '{CW'(3), CW'(2), CW'(2), CW'(2), CW'(1), CW'(0)};
      issue_start(2'd1, 4, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         enable = !(c == 3 || c == 4);
         step();
         n_vec++;
         if (done[1] !== (c == 6) || readout !== exp_ro_tbl[c-1]) begin
            n_err++;
            $display("FAIL pause_c%0d: got done=%b ro=%0d, want done1=%0d ro=%0d",
                     c, done, readout, c == 6, exp_ro_tbl[c-1]);
         end
      end
      enable = 1'b1;
      irq_clr = 4'b0010;
      step();
      irq_clr = 4'b0000;
   endtask

   task automatic test_edges();
      // start with zero count is ignored
      issue_start(2'd3, 0, 1'b0);
      n_vec++;
      if (busy !== 4'b0000 || readout !== '0) begin
         n_err++;
         $display("FAIL zero_start: got busy=%b ro=%0d want 0000/0", busy, readout);
      end
      // start+stop from RUN: stop wins
      issue_start(2'd0, 8, 1'b0);
      ch_sel = 2'd0; cycles = CW'(8); start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      n_vec++;
      if (busy !== 4'b0000 || readout !== '0) begin
         n_err++;
         $display("FAIL start_stop: got busy=%b ro=%0d want 0000/0", busy, readout);
      end
      for (int c = 1; c <= 9; c++) step();
      n_vec++;
      if (done !== 4'b0000 || irq_status !== 4'b0000) begin
         n_err++;
         $display("FAIL start_stop_quiet: got done=%b irqs=%b want 0000/0000", done, irq_status);
      end
      // irq set and clear in the same cycle: set wins
      issue_start(2'd1, 2, 1'b0);
      step();
      irq_clr = 4'b0010;
      step();
      n_vec++;
      if (done !== 4'b0010 || irq_status !== 4'b0010 || irq !== 1'b1) begin
         n_err++;
         $display("FAIL irq_set_clear: got done=%b irqs=%b irq=%b want 0010/0010/1", done, irq_status, irq);
      end
      step();
      irq_clr = 4'b0000;
      n_vec++;
      if (irq_status !== 4'b0000 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL irq_clear_next: got irqs=%b irq=%b want 0000/0", irq_status, irq);
      end
      // select == NUM_CH on the 3-channel instance
      sel3 = 2'd3; cycles = CW'(2); start3 = 1'b1;
      step();
      start3 = 1'b0;
      n_vec++;
      if (busy3 !== 3'b000 || readout3 !== '0) begin
         n_err++;
         $display("FAIL sel_out_of_range_start: got busy=%b ro=%0d want 000/0", busy3, readout3);
      end
      sel3 = 2'd2; start3 = 1'b1;
      step();
      start3 = 1'b0;
      n_vec++;
      if (busy3 !== 3'b100 || readout3 !== CW'(2)) begin
         n_err++;
         $display("FAIL sel_in_range_start: got busy=%b ro=%0d want 100/2", busy3, readout3);
      end
      sel3 = 2'd3; stop3 = 1'b1;
      step();
      stop3 = 1'b0;
      n_vec++;
      if (busy3 !== 3'b100 || readout3 !== '0) begin
         n_err++;
         $display("FAIL sel_out_of_range_stop: got busy=%b ro=%0d want 100/0", busy3, readout3);
      end
      step();
      n_vec++;
      if (done3 !== 3'b100 || busy3 !== 3'b000) begin
         n_err++;
         $display("FAIL sel_expiry: got done=%b busy=%b want 100/000", done3, busy3);
      end
      irq_clr3 = 3'b111;
      step();
      irq_clr3 = 3'b000;
   endtask

   task automatic test_back_to_back();
      issue_start(2'd0, 3, 1'b0);
      step(); step();
      issue_start(2'd0, 4, 1'b0);
      n_vec++;
      if (done !== 4'b0000 || readout !== CW'(4) || busy !== 4'b0001) begin
         n_err++;
         $display("FAIL restart_suppress: got done=%b ro=%0d busy=%b want 0000/4/0001", done, readout, busy);
      end
      for (int d = 1; d <= 4; d++) begin
         step();
         n_vec++;
         if (done[0] !== (d == 4)) begin
            n_err++;
            $display("FAIL restart_d%0d: got done=%b want done0=%0d", d, done, d == 4);
         end
      end
      irq_clr = 4'b1111;
      step();
      irq_clr = 4'b0000;
   endtask

   task automatic test_concurrency();
      int            tbl [4];
      logic [3:0]    exp_done;
      logic [3:0]    exp_busy;
      tbl = '{10, 10, 7, 1};
      enable = 1'b0;
      for (int k = 0; k < 4; k++) issue_start(2'(k), tbl[k], 1'b0);
      ch_sel = 2'd0;
      step();
      n_vec++;
      if (busy !== 4'b1111 || readout !== CW'(10)) begin
         n_err++;
         $display("FAIL conc_loaded: got busy=%b ro=%0d want 1111/10", busy, readout);
      end
      enable = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         exp_done = 4'b0000;
         exp_busy = 4'b0000;
         for (int k = 0; k < 4; k++) begin
            exp_done[k] = (c == tbl[k]);
            exp_busy[k] = (c < tbl[k]);
         end
         n_vec++;
         if (done !== exp_done || busy !== exp_busy) begin
            n_err++;
            $display("FAIL conc_c%0d: got done=%b busy=%b want %b/%b", c, done, busy, exp_done, exp_busy);
         end
      end
      n_vec++;
      if (irq_status !== 4'b1111 || irq !== 1'b1) begin
         n_err++;
         $display("FAIL conc_irqs: got %b/%b want 1111/1", irq_status, irq);
      end
      // reset in the middle of a run, leaving irq_status set
      issue_start(2'd2, 5, 1'b1);
      step();
      rstn_i = 1'b0;
      #1;
      n_vec++;
      if ({readout, busy, done, irq_status, irq} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_run: got ro=%0d busy=%b done=%b irqs=%b irq=%b want all 0",
                  readout, busy, done, irq_status, irq);
      end
      step();
      rstn_i = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         n_vec++;
         if (done !== 4'b0000 || busy !== 4'b0000 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after_c%0d: got done=%b busy=%b irq=%b want 0/0/0", c, done, busy, irq);
         end
      end
   endtask

`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
   task automatic test_prescale();
      prescale = 8'd2;
      issue_start(2'd0, 2, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         step();
         n_vec++;
         if (done[0] !== (c == 6)) begin
            n_err++;
            $display("FAIL prescale2_c%0d: got done=%b want done0=%0d", c, done, c == 6);
         end
      end
      prescale = 8'd0;
      issue_start(2'd0, 2, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         step();
         n_vec++;
         if (done[0] !== (c == 2)) begin
            n_err++;
            $display("FAIL prescale0_c%0d: got done=%b want done0=%0d", c, done, c == 2);
         end
      end
   endtask
`endif

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_pause();
      test_edges();
      test_back_to_back();
      test_concurrency();
`ifdef MULTI_CYCLE_TIMER_PRESCALE_EN
      test_prescale();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "timeout");
   end

endmodule
